// File: rtl/eth_sniffer_pkg.sv
// eth_sniffer_pkg: shared types and constants for the MAC match controller.
//   state_t    : controller FSM states
//   MAC_W      : MAC address width (48)
//   WORD_W     : stream / host word width (32)
//   CFG_MAC_LO : host address of MAC[31:0]
//   CFG_MAC_HI : host address of MAC[47:32] + enable (bit 31)
package eth_sniffer_pkg;

  localparam int MAC_W  = 48;
  localparam int WORD_W = 32;

  localparam logic CFG_MAC_LO = 1'b0;
  localparam logic CFG_MAC_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    FLUSH,
    REPORT
  } state_t;

endpackage

// File: rtl/mac_cfg_regs.sv
// mac_cfg_regs: host-programmed shadow MAC/enable and the committed copy
// seen by the comparator.
//   clk, rst   : clock, asynchronous active-high reset
//   cfg_wr     : one-cycle host write strobe
//   cfg_addr   : CFG_MAC_LO -> MAC[31:0]; CFG_MAC_HI -> MAC[47:32] + enable
//   cfg_wdata  : host write data
//   commit     : copy shadow into the committed registers (high in IDLE)
//   mac        : committed MAC
//   enable     : committed enable
module mac_cfg_regs
  import eth_sniffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic              cfg_addr,
  input  logic [WORD_W-1:0] cfg_wdata,
  input  logic              commit,
  output logic [MAC_W-1:0]  mac,
  output logic              enable
);

  logic [MAC_W-1:0] shadow_mac;
  logic             shadow_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_mac <= '0;
      shadow_en  <= 1'b0;
      mac        <= '0;
      enable     <= 1'b0;
    end else begin
      if (cfg_wr) begin
        if (cfg_addr == CFG_MAC_HI) begin
          // High half and enable land together so the pair is never torn.
          shadow_mac[47:32] <= cfg_wdata[15:0];
          shadow_en         <= cfg_wdata[31];
        end else begin
          shadow_mac[31:0]  <= cfg_wdata;
        end
      end
      // NOTE: non-blocking assignment means commit copies the shadow as it was
      // before this cycle's write; a coincident write shows at the next commit.
      if (commit) begin
        mac    <= shadow_mac;
        enable <= shadow_en;
      end
    end
  end

endmodule

// File: rtl/mac_match_controller.sv
// mac_match_controller: sequences the MAC comparator once per received frame.
// Forwards the first WINDOW_WORDS words of each frame (zero otherwise), waits
// FLUSH_CYCLES for the comparator pipeline, then strobes a verdict and clears
// the comparator. Host MAC writes are committed only while IDLE.
//   clk, rst                     : clock, asynchronous active-high reset
//   cfg_wr/cfg_addr/cfg_wdata    : host programming of MAC + enable
//   in_valid/in_sof/in_eof/in_data, in_ready : receive word stream
//   cmp_mac/cmp_data/cmp_clear, cmp_match    : comparator interface
//   frame_done/frame_match/frame_err         : per-frame verdict
// Build option MATCH_STATS_EN adds stats_clr (in) and match_count[15:0] (out),
// a saturating count of matching verdicts.
module mac_match_controller
  import eth_sniffer_pkg::*;
#(
  parameter int WINDOW_WORDS = 4,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic              cfg_addr,
  input  logic [WORD_W-1:0] cfg_wdata,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic [MAC_W-1:0]  cmp_mac,
  output logic [WORD_W-1:0] cmp_data,
  output logic              cmp_clear,
  input  logic              cmp_match,
  output logic              frame_done,
  output logic              frame_match,
  output logic              frame_err
`ifdef MATCH_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       match_count
`endif
);

  localparam int CNT_W = $clog2(WINDOW_WORDS + 1);
  localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] WIN     = CNT_W'(WINDOW_WORDS);
  localparam logic [FL_W-1:0]  FL_LAST = FL_W'(FLUSH_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [FL_W-1:0]  flush_cnt;
  logic             err_flag;
  logic             enable;
  logic             hs;
  logic             in_window;

  assign hs        = in_valid & in_ready;
  assign in_window = (word_cnt < WIN);

  mac_cfg_regs u_cfg (
    .clk       (clk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .commit    (state == IDLE),
    .mac       (cmp_mac),
    .enable    (enable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      word_cnt    <= '0;
      flush_cnt   <= '0;
      err_flag    <= 1'b0;
      in_ready    <= 1'b1;
      cmp_data    <= '0;
      cmp_clear   <= 1'b0;
      frame_done  <= 1'b0;
      frame_match <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      // NOTE: pulse outputs and the comparator word get a default every cycle,
      // so each branch below only states when they are non-zero.
      cmp_data    <= '0;
      cmp_clear   <= 1'b0;
      frame_done  <= 1'b0;
      frame_match <= 1'b0;
      frame_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hs) begin
            if (in_sof) begin
              cmp_data <= in_data;
              word_cnt <= CNT_W'(1);
              if (in_eof) begin
                state    <= FLUSH;
                in_ready <= 1'b0;
              end else begin
                state    <= FRAME;
              end
            end else begin
              // Stray word outside a frame: dropped, reported with the next frame.
              err_flag <= 1'b1;
            end
          end
        end
        FRAME: begin
          if (hs) begin
            if (in_window) begin
              cmp_data <= in_data;
              word_cnt <= word_cnt + 1'b1;
            end
            if (in_sof) err_flag <= 1'b1;
            if (in_eof) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end else if (in_window) begin
            // The comparator shifts every clock, so a gap inside the window
            // has injected a zero word into the header it is matching.
            err_flag <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt == FL_LAST) begin
            state       <= REPORT;
            frame_done  <= 1'b1;
            frame_match <= cmp_match & enable & (cmp_mac != '0);
            frame_err   <= err_flag;
            cmp_clear   <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        REPORT: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          err_flag  <= 1'b0;
          word_cnt  <= '0;
          flush_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MATCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count <= '0;
    end else if (stats_clr) begin
      match_count <= '0;
    end else if (frame_done && frame_match && (match_count != 16'hFFFF)) begin
      match_count <= match_count + 16'd1;
    end
  end
`endif

endmodule
